free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
//  Circular-buffer free list of physical registers for the N-way R10K-style rename stage.
//  Supplies up to N_WAY free PR tags per cycle to the map table (pr_freelist).
//  Reclaims the old PR mappings (pr_old) of retiring instructions.
//  Rebuilds the free state in one cycle on squash, with no walk.
// PARAMETERS
//  N_WAY       3   dispatch/retire width
//  CDB_BITS    6   PR tag width
//  N_PHYS_REG  64  total physical registers
//  N_ARCH_REG  32  architectural registers; PRs 0..31 are mapped at reset
//  DEPTH = N_PHYS_REG-N_ARCH_REG (32); PTR_BITS = $clog2(DEPTH); CNT_BITS = $clog2(DEPTH+1)
// PORTS
//  clock        in   1                 system clock
//  reset        in   1                 asynchronous, active-high
//  alloc_req    in   N_WAY             dispatch wants a PR per way; thermometer from way 0
//  alloc_gnt    out  N_WAY             alloc_req & (way index < free_cnt)
//  pr_freelist  out  N_WAY*CDB_BITS    way i = buf[head+i]; valid only where alloc_gnt[i]
//  free_cnt     out  CNT_BITS          entries currently free, 0..DEPTH
//  ret_valid    in   N_WAY             retiring way frees ret_pr_old; thermometer from way 0
//  ret_pr_old   in   N_WAY*CDB_BITS    old PR of each retiring dest
//  squash       in   1                 mispredict/exception flush of all un-retired work
//  fl_error     out  1                 sticky overflow/underflow flag (FREELIST_CHECK_EN only)
// BEHAVIOUR
//  - Storage: buf[DEPTH] of CDB_BITS; head (alloc ptr), tail (free ptr), count; indices mod DEPTH.
//  - Reset (async): buf[i] = N_ARCH_REG+i; head = tail = 0; count = DEPTH; fl_error = 0.
//    Outputs after reset: pr_freelist = {34,33,32} (way2..0), free_cnt = 32, alloc_gnt = alloc_req.
//  - Reset asserted mid-operation discards all state immediately.
//  - pr_freelist and alloc_gnt are combinational from head/count; zero-latency peek.
//    Head advances on the clock edge.
//  - Alloc: nA = popcount(alloc_gnt). head += nA at posedge; wraps DEPTH-1 -> 0.
//  - Free: nR = popcount(ret_valid). buf[tail+i] = ret_pr_old[i] for i < nR; tail += nR.
//  - count_next = count - nA + nR. Simultaneous alloc and free are both legal.
//  - A freed PR is not allocatable before the next cycle (no bypass).
//  - Empty (count = 0): alloc_gnt = 0. Dispatch stalls on alloc_req & ~alloc_gnt.
//  - Partial grant: count = 1 with alloc_req = 3'b111 gives alloc_gnt = 3'b001.
//  - Full (count = DEPTH): retire pushes are a protocol violation; the push is still performed.
//  - Squash: alloc is ignored that cycle; retires in the same cycle are applied first.
//    Then head := tail_next and count := DEPTH.
//    Slots [tail, head) still hold the un-retired allocations in order, so this restores
//    exactly "all PRs not in the architectural map".
//  - Non-thermometer alloc_req/ret_valid: undefined; flagged under FREELIST_CHECK_EN.
// CONFIGURATION
//  FREELIST_CHECK_EN defined:
//    fl_error sets (sticky until reset) on: count + nR > DEPTH;
//    alloc_req | ret_valid not thermometer; squash and reset at the same time.
//    Adds immediate assertions; simulation $error on each violation.
//  FREELIST_CHECK_EN undefined: fl_error tied to 0; no check logic, no assertions.
// TESTING
//  1 reset, no activity -> pr_freelist = {34,33,32}, free_cnt = 32, alloc_gnt = alloc_req.
//  2 alloc_req = 111 for 10 cycles, then 011 -> free_cnt = 0.
//    Next alloc_req = 111 -> alloc_gnt = 000, free_cnt stays 0.
//  3 from empty, ret_valid = 111 with ret_pr_old = {7,6,5} -> next cycle pr_freelist = {7,6,5}, free_cnt = 3.
//    Alloc 111 plus retire 111 in the same cycle -> free_cnt unchanged.
//  4 wrap: 40 cycles of 3-wide alloc+retire with incrementing tags.
//    Allocated order equals freed order across head/tail wrap; free_cnt is constant.
//  5 alloc 32..36 (free_cnt 27), then squash -> next cycle free_cnt = 32, pr_freelist = {34,33,32}.
//  6 alloc 111 (gets 32..34), then squash with ret_valid = 001, ret_pr_old[0] = 2.
//    -> free_cnt = 32, pr_freelist = {35,34,33}; PR 2 is allocated 32 slots later.
//  7 reset pulsed mid-stream (between clock edges) -> outputs return to reset values before the next edge.
//  8 FREELIST_CHECK_EN: retire 001 when free_cnt = 32 -> fl_error = 1 next cycle, held until reset.

Source files
------------

// File: rtl/free_list.sv
// Circular free list of physical register tags for an N-way rename stage; squash restores in one cycle.
// Optional checking (sticky fl_error plus assertions) is enabled by defining FREELIST_CHECK_EN.
module free_list #(
  parameter int N_WAY      = 3,
  parameter int CDB_BITS   = 6,
  parameter int N_PHYS_REG = 64,
  parameter int N_ARCH_REG = 32,
  localparam int DEPTH     = N_PHYS_REG - N_ARCH_REG,
  localparam int PTR_BITS  = $clog2(DEPTH),
  localparam int CNT_BITS  = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_WAY-1:0]          alloc_req,
  output logic [N_WAY-1:0]          alloc_gnt,
  output logic [N_WAY*CDB_BITS-1:0] pr_freelist,
  output logic [CNT_BITS-1:0]       free_cnt,
  input  logic [N_WAY-1:0]          ret_valid,
  input  logic [N_WAY*CDB_BITS-1:0] ret_pr_old,
  input  logic                      squash,
  output logic                      fl_error
);

  logic [CDB_BITS-1:0] slot_q [DEPTH];
  logic [CDB_BITS-1:0] slot_d [DEPTH];
  logic [PTR_BITS-1:0] head_q, head_d;
  logic [PTR_BITS-1:0] tail_q, tail_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] n_alloc;
  logic [CNT_BITS-1:0] n_ret;

  function automatic logic [PTR_BITS-1:0] ptr_add(input logic [PTR_BITS-1:0] p,
                                                  input logic [CNT_BITS-1:0] k);
    logic [CNT_BITS:0] s;
    s = (CNT_BITS+1)'(p) + (CNT_BITS+1)'(k);
    if (s >= (CNT_BITS+1)'(DEPTH)) s = s - (CNT_BITS+1)'(DEPTH);
    return PTR_BITS'(s);
  endfunction

  // Handshake: alloc_req is a request per way; the tag on a way is consumed at the clock
  // edge exactly when alloc_gnt is high on that way (and no squash). A request without a
  // grant is a stall, retried by the requester. Retire pushes are unconditional.
  always_comb begin
    alloc_gnt   = '0;
    pr_freelist = '0;
    n_alloc     = '0;
    n_ret       = '0;
    for (int i = 0; i < N_WAY; i++) begin
      alloc_gnt[i] = alloc_req[i] && (CNT_BITS'(i) < cnt_q);
      pr_freelist[i*CDB_BITS +: CDB_BITS] = slot_q[ptr_add(head_q, CNT_BITS'(i))];
      if (alloc_gnt[i]) n_alloc = n_alloc + CNT_BITS'(1);
      if (ret_valid[i]) n_ret = n_ret + CNT_BITS'(1);
    end
  end

  assign free_cnt = cnt_q;

  always_comb begin
    slot_d = slot_q;
    for (int i = 0; i < N_WAY; i++) begin
      if (CNT_BITS'(i) < n_ret)
        slot_d[ptr_add(tail_q, CNT_BITS'(i))] = ret_pr_old[i*CDB_BITS +: CDB_BITS];
    end
    tail_d = ptr_add(tail_q, n_ret);
    // Slots [tail, head) still hold the in-flight tags, so pulling head back to the
    // post-retire tail frees exactly every register outside the architectural map.
    if (squash) begin
      head_d = tail_d;
      cnt_d  = CNT_BITS'(DEPTH);
    end else begin
      head_d = ptr_add(head_q, n_alloc);
      cnt_d  = cnt_q - n_alloc + n_ret;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= CDB_BITS'(N_ARCH_REG + i);
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= CNT_BITS'(DEPTH);
    end else begin
      slot_q <= slot_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef FREELIST_CHECK_EN
  logic err_q, err_d;
  logic overfill, bad_alloc, bad_ret;

  function automatic logic is_thermo(input logic [N_WAY-1:0] x);
    return (x & (x + N_WAY'(1))) == '0;
  endfunction

  always_comb begin
    overfill  = ((CNT_BITS+1)'(cnt_q) + (CNT_BITS+1)'(n_ret)) > (CNT_BITS+1)'(DEPTH);
    bad_alloc = !is_thermo(alloc_req);
    bad_ret   = !is_thermo(ret_valid);
    err_d     = err_q | overfill | bad_alloc | bad_ret;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  always @(posedge clock) begin
    a_squash_reset: assert (!(squash && reset)) else $error("free_list: squash during reset");
    if (!reset) begin
      a_overfill:  assert (!overfill)  else $error("free_list: retire push beyond capacity");
      a_alloc_th:  assert (!bad_alloc) else $error("free_list: alloc_req not thermometer");
      a_ret_th:    assert (!bad_ret)   else $error("free_list: ret_valid not thermometer");
    end
  end

  assign fl_error = err_q;
`else
  assign fl_error = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: a driver pushes hand-computed expected outputs per cycle,
// a monitor pops and compares them on the falling edge (or on demand for async reset).
module tb_free_list;
  localparam int W = 28;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  alloc_req = '0;
  logic [2:0]  alloc_gnt;
  logic [17:0] pr_freelist;
  logic [5:0]  free_cnt;
  logic [2:0]  ret_valid = '0;
  logic [17:0] ret_pr_old = '0;
  logic        squash = 1'b0;
  logic        fl_error;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  event         chk_ev;

  free_list dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .pr_freelist(pr_freelist), .free_cnt(free_cnt),
    .ret_valid(ret_valid), .ret_pr_old(ret_pr_old),
    .squash(squash), .fl_error(fl_error)
  );

  always #5 clock = ~clock;

  function automatic logic [17:0] pr3(input int a2, input int a1, input int a0);
    return {6'(a2), 6'(a1), 6'(a0)};
  endfunction

  // Called at posedge+1: apply inputs, queue the outputs expected during this cycle.
  task automatic drive(input logic [2:0] areq, input logic [2:0] rv, input logic [17:0] rpr,
                       input logic sq, input logic [2:0] egnt, input logic [17:0] epr,
                       input logic [5:0] ecnt, input logic efl, input string nm);
    alloc_req  = areq;
    ret_valid  = rv;
    ret_pr_old = rpr;
    squash     = sq;
    exp_q.push_back({efl, ecnt, egnt, epr});
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  task automatic reset_pulse();
    alloc_req = '0; ret_valid = '0; ret_pr_old = '0; squash = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin : monitor
    logic [W-1:0] e, g;
    string        nm;
    forever begin
      @(negedge clock or chk_ev);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        g  = {fl_error, free_cnt, alloc_gnt, pr_freelist};
        for (int i = 0; i < 3; i++) begin
          if (!e[18+i]) begin
            e[i*6 +: 6] = '0;
            g[i*6 +: 6] = '0;
          end
        end
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL %s: got fl=%0d cnt=%0d gnt=%b pr=%0d/%0d/%0d, expected fl=%0d cnt=%0d gnt=%b pr=%0d/%0d/%0d",
                   nm, g[27], g[26:21], g[20:18], g[17:12], g[11:6], g[5:0],
                   e[27], e[26:21], e[20:18], e[17:12], e[11:6], e[5:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // 1: reset state
    drive(3'b000, 3'b000, '0, 1'b0, 3'b000, pr3(34, 33, 32), 6'd32, 1'b0, "t1_reset");

    // 2: drain to empty
    for (int k = 0; k < 10; k++)
      drive(3'b111, 3'b000, '0, 1'b0, 3'b111, pr3(34+3*k, 33+3*k, 32+3*k), 6'(32-3*k), 1'b0, "t2_alloc");
    drive(3'b011, 3'b000, '0, 1'b0, 3'b011, pr3(0, 63, 62), 6'd2, 1'b0, "t2_last_two");
    drive(3'b111, 3'b000, '0, 1'b0, 3'b000, '0, 6'd0, 1'b0, "t2_empty_stall");
    drive(3'b000, 3'b000, '0, 1'b0, 3'b000, '0, 6'd0, 1'b0, "t2_empty_hold");

    // 3: refill from empty, then simultaneous alloc and retire
    drive(3'b000, 3'b111, pr3(7, 6, 5), 1'b0, 3'b000, '0, 6'd0, 1'b0, "t3_retire");
    drive(3'b111, 3'b111, pr3(10, 9, 8), 1'b0, 3'b111, pr3(7, 6, 5), 6'd3, 1'b0, "t3_alloc_retire");
    drive(3'b000, 3'b000, '0, 1'b0, 3'b000, '0, 6'd3, 1'b0, "t3_cnt_steady");

    // 4: steady 3-wide traffic across several pointer wraps
    for (int j = 0; j < 40; j++)
      drive(3'b111, 3'b111, pr3(13+3*j, 12+3*j, 11+3*j), 1'b0,
            3'b111, pr3(10+3*j, 9+3*j, 8+3*j), 6'd3, 1'b0, "t4_wrap");

    // 7: asynchronous reset between edges
    alloc_req = 3'b111; ret_valid = '0; squash = 1'b0;
    #2 reset = 1'b1;
    #1;
    exp_q.push_back({1'b0, 6'd32, 3'b111, pr3(34, 33, 32)});
    name_q.push_back("t7_async_reset");
    -> chk_ev;
    #1 alloc_req = '0;
    #2 reset = 1'b0;
    @(posedge clock);
    #1;

    // 5: allocate 32..36 then squash
    drive(3'b111, 3'b000, '0, 1'b0, 3'b111, pr3(34, 33, 32), 6'd32, 1'b0, "t5_alloc3");
    drive(3'b011, 3'b000, '0, 1'b0, 3'b011, pr3(0, 36, 35), 6'd29, 1'b0, "t5_alloc2");
    drive(3'b111, 3'b000, '0, 1'b1, 3'b111, pr3(39, 38, 37), 6'd27, 1'b0, "t5_squash");
    drive(3'b111, 3'b000, '0, 1'b0, 3'b111, pr3(34, 33, 32), 6'd32, 1'b0, "t5_restored");

    // 6: squash with a same-cycle retire of PR 2
    drive(3'b000, 3'b001, pr3(0, 0, 2), 1'b1, 3'b000, '0, 6'd29, 1'b0, "t6_squash_retire");
    drive(3'b111, 3'b000, '0, 1'b0, 3'b111, pr3(35, 34, 33), 6'd32, 1'b0, "t6_restored");
    for (int k = 0; k < 9; k++)
      drive(3'b111, 3'b000, '0, 1'b0, 3'b111, pr3(38+3*k, 37+3*k, 36+3*k), 6'(29-3*k), 1'b0, "t6_drain");
    drive(3'b011, 3'b000, '0, 1'b0, 3'b011, pr3(0, 2, 63), 6'd2, 1'b0, "t6_pr2_reused");

`ifdef FREELIST_CHECK_EN
    // 8: overfill sets the sticky error flag
    reset_pulse();
    drive(3'b000, 3'b001, pr3(0, 0, 40), 1'b0, 3'b000, '0, 6'd32, 1'b0, "t8_overfill");
    drive(3'b000, 3'b000, '0, 1'b0, 3'b000, '0, 6'd33, 1'b1, "t8_err_set");
    drive(3'b000, 3'b000, '0, 1'b0, 3'b000, '0, 6'd33, 1'b1, "t8_err_hold");
    reset_pulse();
    drive(3'b000, 3'b000, '0, 1'b0, 3'b000, '0, 6'd32, 1'b0, "t8_err_cleared");
`endif

    alloc_req = '0; ret_valid = '0; squash = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
